// File: rtl/feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feeder_pkg
// Description : Feeder FSM state encoding and default 50 MHz timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } feed_state_t;

    localparam int unsigned DEF_CYC_PER_MS = 50000;
    localparam int unsigned DEF_PERIOD_CYC = 1000000;
    localparam int unsigned DEF_CLOSED_CYC = 50000;
    localparam int unsigned DEF_OPEN_CYC   = 100000;
    localparam int unsigned DEF_SETTLE_MS  = 500;
    localparam int unsigned DEF_MAX_DUR_MS = 10000;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen
// Description : Free-running servo PWM frame generator with frame-aligned width.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_gen
    import feeder_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [$clog2(PERIOD_CYC+1)-1:0] width_req,
    output logic                            pwm
);

    localparam int unsigned CW = $clog2(PERIOD_CYC + 1);

    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] width_q;
    logic [CW-1:0] eff_width;
    logic          frame_start;

    // The first cycle of a frame compares against the fresh request so a
    // width change never produces a runt or stretched pulse.
    assign frame_start = (frame_cnt == '0);
    assign eff_width   = frame_start ? width_req : width_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            width_q   <= '0;
            pwm       <= 1'b0;
        end else begin
            pwm <= (frame_cnt < eff_width);
            if (frame_start) begin
                width_q <= width_req;
            end
            if (frame_cnt == CW'(PERIOD_CYC - 1)) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/feed_motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : feed_motor_driver
// Description : Feed request sequencer: opens the servo for the requested time,
//               settles closed, then pulses completion and counts feeds.
// Revision    : 1.0 - initial release
// ============================================================================
module feed_motor_driver
    import feeder_pkg::*;
#(
    parameter int unsigned CYC_PER_MS = DEF_CYC_PER_MS,
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int unsigned CLOSED_CYC = DEF_CLOSED_CYC,
    parameter int unsigned OPEN_CYC   = DEF_OPEN_CYC,
    parameter int unsigned SETTLE_MS  = DEF_SETTLE_MS,
    parameter int unsigned MAX_DUR_MS = DEF_MAX_DUR_MS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        feed_req,
    input  logic [31:0] duration,
    input  logic        cancel,
    output logic        motorPWM,
    output logic        busy,
    output logic        feedDone,
    output logic [15:0] feedCount
);

    localparam int unsigned PW = $clog2(PERIOD_CYC + 1);
    localparam int unsigned DW = $clog2(MAX_DUR_MS + 1);
    localparam int unsigned MW = cnt_width(CYC_PER_MS);
    localparam int unsigned SW = cnt_width(SETTLE_MS);

    feed_state_t   state;
    feed_state_t   state_next;

    logic          req_sync;
    logic          req_q;
    logic          start;
    logic [MW-1:0] ms_cnt;
    logic          tick;
    logic [DW-1:0] dur_q;
    logic [DW-1:0] sat_dur;
    logic [SW-1:0] settle_cnt;
    logic [15:0]   count_q;
    logic [PW-1:0] width_req;
    logic          state_change;

    // feed_req comes from a CPU register; one sync stage, then edge detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_sync <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            req_sync <= feed_req;
            req_q    <= req_sync;
        end
    end

    assign start   = req_sync & ~req_q;
    assign tick    = (ms_cnt == MW'(CYC_PER_MS - 1));
    assign sat_dur = (duration > 32'(MAX_DUR_MS)) ? DW'(MAX_DUR_MS) : duration[DW-1:0];
    assign state_change = (state_next != state);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        feedDone   = 1'b0;
        width_req  = PW'(CLOSED_CYC);
        case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    state_next = (sat_dur == '0) ? ST_SETTLE : ST_OPEN;
                end
            end
            ST_OPEN: begin
                busy      = 1'b1;
                width_req = PW'(OPEN_CYC);
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (tick && dur_q == DW'(1)) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (tick && settle_cnt == SW'(SETTLE_MS - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                feedDone   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Restarting the ms counter on every state entry makes each phase an
    // exact multiple of CYC_PER_MS cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ms_cnt <= '0;
        end else if (state_change || tick) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + MW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dur_q <= '0;
        end else if (state == ST_IDLE && state_change) begin
            dur_q <= sat_dur;
        end else if (state == ST_OPEN && tick) begin
            dur_q <= dur_q - DW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
        end else if (state_change) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE && tick) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (state == ST_DONE) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign feedCount = count_q;

    servo_pwm_gen #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_pwm (
        .clock     (clock),
        .reset     (reset),
        .width_req (width_req),
        .pwm       (motorPWM)
    );

endmodule
`default_nettype wire

// File: tb/tb_feed_motor_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_feed_motor_driver
// Description : Self-checking bench for feed_motor_driver with a feed scoreboard
//               and a cycle model of the frame-aligned PWM widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feed_motor_driver;

    localparam int CPM  = 10;
    localparam int PER  = 200;
    localparam int CLO  = 10;
    localparam int OPN  = 20;
    localparam int STL  = 2;
    localparam int MAXD = 50;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        feed_req = 1'b0;
    logic        cancel   = 1'b0;
    logic [31:0] duration = 32'd0;
    logic        motorPWM;
    logic        busy;
    logic        feedDone;
    logic [15:0] feedCount;

    feed_motor_driver #(
        .CYC_PER_MS (CPM),
        .PERIOD_CYC (PER),
        .CLOSED_CYC (CLO),
        .OPEN_CYC   (OPN),
        .SETTLE_MS  (STL),
        .MAX_DUR_MS (MAXD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .feed_req  (feed_req),
        .duration  (duration),
        .cancel    (cancel),
        .motorPWM  (motorPWM),
        .busy      (busy),
        .feedDone  (feedDone),
        .feedCount (feedCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        int busy_len;
        bit done;
        int count;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  k = 0;
    int  open_lo = 0;
    int  open_hi = 0;
    int  exp_count = 0;
    int  frame_w = CLO;
    int  hi_cnt = 0;
    int  busy_run = 0;
    bit  prev_busy = 1'b0;
    bit  count_pending = 1'b0;
    int  pending_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // k = posedges since reset release, as seen at each falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            k             = 0;
            hi_cnt        = 0;
            frame_w       = CLO;
            busy_run      = 0;
            prev_busy     = 1'b0;
            count_pending = 1'b0;
        end else begin
            k++;
            if (count_pending) begin
                chk("feed_count", feedCount, pending_count);
                count_pending = 1'b0;
            end
            hi_cnt += int'(motorPWM);
            if (k % PER == 1) chk("frame_start", motorPWM, 1);
            if (k % PER == 0) begin
                chk("pulse_width", hi_cnt, frame_w);
                hi_cnt  = 0;
                frame_w = (k >= open_lo && k < open_hi) ? OPN : CLO;
            end
            if (busy) busy_run++;
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    sb_t item;
                    item = sb.pop_front();
                    chk("busy_len", busy_run, item.busy_len);
                    chk("feed_done", feedDone, item.done);
                    pending_count = item.count;
                    count_pending = 1'b1;
                end
                busy_run = 0;
            end else begin
                chk("no_stray_done", feedDone, 0);
            end
            prev_busy = busy;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic start_feed(input logic [31:0] d);
        int ds;
        ds       = (d > 32'(MAXD)) ? MAXD : int'(d);
        duration = d;
        feed_req = 1'b1;
        open_lo  = k + 2;
        open_hi  = k + 2 + ds * CPM;
        exp_count++;
        sb.push_back('{ds * CPM + STL * CPM, 1'b1, exp_count});
        cycles(1);
        chk("busy_lat1", busy, 0);
        cycles(1);
        chk("busy_lat2", busy, 1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && busy; i++) cycles(1);
        chk("idle_timeout", busy, 0);
        cycles(3);
    endtask

    task automatic do_cancel();
        cancel  = 1'b1;
        if (open_hi > k + 1) open_hi = k + 1;
        sb[sb.size()-1].busy_len = k + 1 - open_lo;
        sb[sb.size()-1].done     = 1'b0;
        exp_count--;
        sb[sb.size()-1].count    = exp_count;
        cycles(1);
        cancel = 1'b0;
        chk("cancel_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", feedDone, 0);
        chk("rst_count", feedCount, 0);
        chk("rst_pwm", motorPWM, 0);
        reset = 1'b1;

        cycles(1000);
        chk("idle_busy", busy, 0);
        chk("idle_count", feedCount, 0);

        start_feed(32'd5);
        wait_idle(200);
        feed_req = 1'b0;
        cycles(3);

        start_feed(32'd0);
        wait_idle(200);
        feed_req = 1'b0;
        cycles(3);

        start_feed(32'hFFFF_FFFF);
        wait_idle(1000);
        feed_req = 1'b0;
        cycles(3);

        start_feed(32'd30);
        cycles(50);
        feed_req = 1'b0;
        cycles(3);
        feed_req = 1'b1;
        cycles(open_hi + 5 - k);
        do_cancel();
        cycles(400);
        chk("cancel_count", feedCount, exp_count);
        feed_req = 1'b0;
        cycles(3);

        feed_req = 1'b1;
        cycles(1);
        cancel = 1'b1;
        cycles(1);
        cancel = 1'b0;
        cycles(5);
        chk("cancel_start_busy", busy, 0);
        chk("cancel_start_count", feedCount, exp_count);
        feed_req = 1'b0;
        cycles(3);

        start_feed(32'd40);
        for (int i = 0; i < 400 && !motorPWM; i++) cycles(1);
        chk("pwm_seen_high", motorPWM, 1);
        sb.delete();
        open_lo   = 0;
        open_hi   = 0;
        exp_count = 0;
        reset     = 1'b0;
        #1;
        chk("async_rst_pwm", motorPWM, 0);
        chk("async_rst_busy", busy, 0);
        feed_req = 1'b0;
        cycles(3);
        chk("async_rst_count", feedCount, 0);
        reset = 1'b1;
        cycles(600);

        start_feed(32'd3);
        wait_idle(200);
        feed_req = 1'b0;
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
